// File: rtl/tone_scheduler_pkg.sv
// Shared types and constants for the tone scheduler.
// Optional melody playback is compiled in with TONE_SCHED_PLAYBACK_EN.
package tone_pkg;

    typedef enum logic [1:0] {
        NOTE_C = 2'd0,
        NOTE_D = 2'd1,
        NOTE_E = 2'd2,
        NOTE_G = 2'd3
    } note_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Divider limit per note, in clk_audio cycles minus one (indexed by note_t)
    localparam logic [11:0] NOTE_LIMIT [4] = '{12'hBAA, 12'hA64, 12'h941, 12'h7C9};

`ifdef TONE_SCHED_PLAYBACK_EN
    localparam int unsigned MELODY_LEN = 8;
    localparam note_t MELODY [MELODY_LEN] = '{NOTE_C, NOTE_D, NOTE_E, NOTE_C,
                                             NOTE_E, NOTE_G, NOTE_E, NOTE_D};
`endif

endpackage

// File: rtl/tone_scheduler_if.sv
// Key inputs and tone outputs of the tone scheduler.
// Playback request/status exist only with TONE_SCHED_PLAYBACK_EN.
interface tone_scheduler_if;
    logic       do_nota;
    logic       re_nota;
    logic       mi_nota;
    logic       sol_nota;
    logic [4:0] rom_addr;
    logic [1:0] note_sel;
    logic       tone_en;
    logic       step;
`ifdef TONE_SCHED_PLAYBACK_EN
    logic       play_start;
    logic       play_busy;
`endif

    modport master (
        output do_nota, re_nota, mi_nota, sol_nota,
`ifdef TONE_SCHED_PLAYBACK_EN
        output play_start,
        input  play_busy,
`endif
        input  rom_addr, note_sel, tone_en, step
    );

    modport slave (
        input  do_nota, re_nota, mi_nota, sol_nota,
`ifdef TONE_SCHED_PLAYBACK_EN
        input  play_start,
        output play_busy,
`endif
        output rom_addr, note_sel, tone_en, step
    );
endinterface

// File: rtl/tone_divider.sv
// Rate divider for the sine ROM address: counts 0..limit and flags the
// limit cycle as a step; held at zero while clr is asserted.
module tone_divider (
    input  logic        clk_audio,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [11:0] limit,
    output logic        step
);
    logic [11:0] cnt_q;

    // Counter: clear when idle, wrap to zero after the limit cycle
    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == limit)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 12'd1;
        end
    end

    assign step = !clr && (cnt_q == limit);
endmodule

// File: rtl/tone_scheduler.sv
// Tone sequencer/arbiter: synchronizes the note keys, paces the sine ROM
// address at the selected note's rate and changes or stops notes only at
// waveform phase zero. TONE_SCHED_PLAYBACK_EN adds a fixed 8-note melody.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NOTE_WAVES  = 64
) (
    input  logic            clk_audio,
    input  logic            rst_n,
    tone_scheduler_if.slave bus
);
    if (SYNC_STAGES < 2 || NOTE_WAVES < 1) begin : g_bad_cfg
        $error("tone_scheduler: SYNC_STAGES must be >= 2 and NOTE_WAVES >= 1");
    end

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] keys_raw;
    logic [3:0] keys;
    logic       req_valid;
    note_t      req_note;
    state_t     state_q, state_d;
    note_t      note_q, note_d;
    logic [4:0] addr_q, addr_d;
    logic       div_step;
    logic       wrap;

    assign keys_raw = {bus.sol_nota, bus.mi_nota, bus.re_nota, bus.do_nota};
    assign keys     = sync_q[SYNC_STAGES-1];

    // Key synchronizer chain, newest sample in stage 0
    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], keys_raw};
        end
    end

    // Priority request: do > re > mi > sol
    always_comb begin
        req_valid = |keys;
        req_note  = NOTE_C;
        if (keys[0])      req_note = NOTE_C;
        else if (keys[1]) req_note = NOTE_D;
        else if (keys[2]) req_note = NOTE_E;
        else if (keys[3]) req_note = NOTE_G;
    end

    tone_divider u_div (
        .clk_audio (clk_audio),
        .rst_n     (rst_n),
        .clr       (state_q == ST_IDLE),
        .limit     (NOTE_LIMIT[note_q]),
        .step      (div_step)
    );

    assign wrap = div_step && (addr_q == 5'd31);

`ifdef TONE_SCHED_PLAYBACK_EN
    localparam int unsigned WAVE_W = (NOTE_WAVES > 1) ? $clog2(NOTE_WAVES) : 1;
    logic [WAVE_W-1:0] wave_q, wave_d;
    logic [2:0]        mel_q, mel_d;
    logic              busy_q, busy_d;

    // Melody position registers
    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            wave_q <= '0;
            mel_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            wave_q <= wave_d;
            mel_q  <= mel_d;
            busy_q <= busy_d;
        end
    end

    assign bus.play_busy = busy_q;
`endif

    // Controller state registers
    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            note_q  <= NOTE_C;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: start on request, decide switch/stop only at the wrap step
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        addr_d  = addr_q;
`ifdef TONE_SCHED_PLAYBACK_EN
        wave_d  = wave_q;
        mel_d   = mel_q;
        busy_d  = busy_q;
`endif
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (req_valid) begin
                    note_d  = req_note;
                    state_d = ST_PLAY;
                end
`ifdef TONE_SCHED_PLAYBACK_EN
                else if (bus.play_start) begin
                    busy_d  = 1'b1;
                    mel_d   = '0;
                    wave_d  = '0;
                    note_d  = MELODY[0];
                    state_d = ST_PLAY;
                end
`endif
            end
            ST_PLAY: begin
                if (div_step) addr_d = addr_q + 5'd1;
                if (wrap) begin
`ifdef TONE_SCHED_PLAYBACK_EN
                    // Melody advances only while no key is requesting;
                    // a key request aborts playback and is served like idle play.
                    if (busy_q && !req_valid) begin
                        if (wave_q == WAVE_W'(NOTE_WAVES - 1)) begin
                            wave_d = '0;
                            if (mel_q == 3'(MELODY_LEN - 1)) begin
                                busy_d  = 1'b0;
                                state_d = ST_IDLE;
                            end else begin
                                mel_d  = mel_q + 3'd1;
                                note_d = MELODY[mel_q + 3'd1];
                            end
                        end else begin
                            wave_d = wave_q + 1'b1;
                        end
                    end else begin
                        busy_d = 1'b0;
                        if (!req_valid) state_d = ST_IDLE;
                        else            note_d  = req_note;
                    end
`else
                    if (!req_valid) state_d = ST_IDLE;
                    else            note_d  = req_note;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rom_addr = addr_q;
    assign bus.note_sel = note_q;
    assign bus.tone_en  = (state_q == ST_PLAY);
    assign bus.step     = div_step;
endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: cycle-level comparison against a
// timeline model (notes described by start time and period), plus literal
// checks of the key scenarios. Playback scenarios need TONE_SCHED_PLAYBACK_EN.
`timescale 1ns/1ps
module tb_tone_scheduler;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned WAVES = 1;
    localparam int WAVE_MAX = 32 * 2987;
`ifdef TONE_SCHED_PLAYBACK_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif

    logic clk_audio = 1'b0;
    logic rst_n     = 1'b0;
    logic pstart    = 1'b0;
    logic dut_busy;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    bit   done         = 1'b0;

    always #5 clk_audio = ~clk_audio;
    always @(posedge clk_audio) cyc++;

    tone_scheduler_if bus();

    tone_scheduler #(.SYNC_STAGES(SYNC), .NOTE_WAVES(WAVES)) dut (
        .clk_audio (clk_audio),
        .rst_n     (rst_n),
        .bus       (bus)
    );

`ifdef TONE_SCHED_PLAYBACK_EN
    assign bus.play_start = pstart;
    assign dut_busy       = bus.play_busy;
`else
    assign dut_busy       = 1'b0;
`endif

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $finish;
        end
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- timeline model ----------------
    function automatic int limit_of(input int n);
        case (n)
            0:       return 2986;
            1:       return 2660;
            2:       return 2369;
            default: return 1993;
        endcase
    endfunction

    function automatic int top_key(input logic [3:0] k);
        if (k[0]) return 0;
        if (k[1]) return 1;
        if (k[2]) return 2;
        if (k[3]) return 3;
        return -1;
    endfunction

    int mel [8] = '{0, 1, 2, 0, 2, 3, 2, 1};
    logic [3:0] hist [SYNC];
    int m_play, m_note, m_el, m_busy, m_idx, m_wcnt;

    // m_el = cycles elapsed since the current waveform started
    always @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 4'b0;
            m_play = 0; m_note = 0; m_el = 0; m_busy = 0; m_idx = 0; m_wcnt = 0;
        end else begin
            int req;
            int per;
            req = top_key(hist[SYNC-1]);
            per = limit_of(m_note) + 1;
            if (m_play == 0) begin
                if (req >= 0) begin
                    m_play = 1; m_note = req; m_el = 0;
                end else if (PB && pstart) begin
                    m_play = 1; m_busy = 1; m_idx = 0; m_wcnt = 0; m_note = mel[0]; m_el = 0;
                end
            end else if (m_el == 32 * per - 1) begin
                m_el = 0;
                if (m_busy != 0 && req < 0) begin
                    m_wcnt++;
                    if (m_wcnt == WAVES) begin
                        m_wcnt = 0;
                        m_idx++;
                        if (m_idx == 8) begin
                            m_busy = 0; m_play = 0;
                        end else begin
                            m_note = mel[m_idx];
                        end
                    end
                end else begin
                    m_busy = 0;
                    if (req < 0) m_play = 0;
                    else         m_note = req;
                end
            end else begin
                m_el++;
            end
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {bus.sol_nota, bus.mi_nota, bus.re_nota, bus.do_nota};
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_audio) begin
        if (!done) begin
            int per;
            int e_addr;
            int e_step;
            per    = limit_of(m_note) + 1;
            e_addr = (m_play != 0) ? (m_el / per) % 32 : 0;
            e_step = (m_play != 0 && (m_el % per) == per - 1) ? 1 : 0;
            tests_run++;
            if (bus.tone_en !== m_play[0] || bus.note_sel !== m_note[1:0] ||
                bus.rom_addr !== e_addr[4:0] || bus.step !== e_step[0] || dut_busy !== m_busy[0]) begin
                tests_failed++;
                $display("FAIL cycle %0d outputs: got en=%0d note=%0d addr=%0d step=%0d busy=%0d, expected en=%0d note=%0d addr=%0d step=%0d busy=%0d",
                         cyc, bus.tone_en, bus.note_sel, bus.rom_addr, bus.step, dut_busy,
                         m_play, m_note, e_addr, e_step, m_busy);
            end
            if (tests_failed >= 40) finish_run();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_keys(input logic [3:0] k);
        {bus.sol_nota, bus.mi_nota, bus.re_nota, bus.do_nota} = k;
    endtask

    task automatic next_edge();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) next_edge();
    endtask

    // kind 0: addr==val, 1: tone_en==val, 2: note_sel!=val, 3: note_sel==val, 4: step==val
    task automatic wait_for(input int kind, input int val, input int budget, input string name);
        int n;
        bit hit;
        n = 0;
        forever begin
            @(negedge clk_audio);
            case (kind)
                0:       hit = (bus.rom_addr == val[4:0]);
                1:       hit = (bus.tone_en  == val[0]);
                2:       hit = (bus.note_sel != val[1:0]);
                3:       hit = (bus.note_sel == val[1:0]);
                default: hit = (bus.step     == val[0]);
            endcase
            if (hit) break;
            n++;
            if (n >= budget) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s: timeout after %0d cycles, got condition false, required kind %0d value %0d", name, budget, kind, val);
                break;
            end
        end
    endtask

    initial begin
        #300_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: got no end of run, required completion");
        finish_run();
    end

    initial begin
        int t_en, t1, t2, steps_in, prev, busy_bad;
        int seq [$];
        logic [3:0] k;
        drive_keys(4'b0);
        cycles(3);
        @(negedge clk_audio);
        check("reset tone_en", bus.tone_en, 0);
        check("reset rom_addr", bus.rom_addr, 0);
        check("reset note_sel", bus.note_sel, 0);
        check("reset step", bus.step, 0);
        check("reset play_busy", dut_busy, 0);

        // re held from reset release
        next_edge();
        drive_keys(4'b0010);
        rst_n = 1'b1;
        cycles(2);
        check("re tone_en before sync", bus.tone_en, 0);
        next_edge();
        check("re tone_en after 3 cycles", bus.tone_en, 1);
        check("re note_sel", bus.note_sel, 1);
        t_en = cyc;
        wait_for(0, 1, 3000, "first addr advance");
        check("first advance latency", cyc - t_en, 32'hA65);
        wait_for(4, 1, 3000, "step seen");
        t1 = cyc;
        wait_for(4, 0, 10, "step low");
        wait_for(4, 1, 3000, "next step");
        t2 = cyc;
        check("D step period", t2 - t1, 32'hA65);
        next_edge();
        drive_keys(4'b0);
        wait_for(1, 0, WAVE_MAX + 100, "idle after D");
        check("idle rom_addr after D", bus.rom_addr, 0);

        // do and sol together, then mi requested mid-waveform
        next_edge();
        drive_keys(4'b1001);
        cycles(3);
        check("do+sol tone_en", bus.tone_en, 1);
        check("do+sol note_sel", bus.note_sel, 0);
        cycles(1000);
        drive_keys(4'b0100);
        wait_for(3, 2, WAVE_MAX + 100, "switch C to E");
        check("E start rom_addr", bus.rom_addr, 0);

        // do pressed at addr 10 during E
        wait_for(0, 10, WAVE_MAX, "E addr 10");
        next_edge();
        drive_keys(4'b0101);
        wait_for(0, 31, WAVE_MAX, "E addr 31");
        check("E held until wrap", bus.note_sel, 2);
        wait_for(2, 2, 4000, "switch at wrap");
        check("switched note_sel", bus.note_sel, 0);
        check("switched rom_addr", bus.rom_addr, 0);

        // release at addr 5, short press of re in between is ignored
        wait_for(0, 5, WAVE_MAX, "C addr 5");
        next_edge();
        drive_keys(4'b0);
        wait_for(0, 10, WAVE_MAX, "C addr 10");
        next_edge();
        drive_keys(4'b0010);
        cycles(100);
        drive_keys(4'b0);
        wait_for(0, 31, WAVE_MAX, "C addr 31");
        check("stepping continues after release", bus.tone_en, 1);
        wait_for(1, 0, 4000, "stop at wrap");
        check("stopped rom_addr", bus.rom_addr, 0);
        check("stopped note_sel", bus.note_sel, 0);

        // asynchronous reset in the middle of G
        next_edge();
        drive_keys(4'b1000);
        wait_for(1, 1, 10, "G start");
        check("G note_sel", bus.note_sel, 3);
        wait_for(0, 17, WAVE_MAX, "G addr 17");
        next_edge();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tone_en", bus.tone_en, 0);
        check("async reset rom_addr", bus.rom_addr, 0);
        check("async reset note_sel", bus.note_sel, 0);
        check("async reset step", bus.step, 0);
        drive_keys(4'b0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // randomized key activity
        t1 = cyc;
        while (cyc - t1 < 150000) begin
            k = 4'($urandom) & 4'($urandom);
            drive_keys(k);
            cycles($urandom_range(1, 6000));
        end
        drive_keys(4'b0);
        wait_for(1, 0, WAVE_MAX + 100, "idle after random");

`ifdef TONE_SCHED_PLAYBACK_EN
        // full melody
        next_edge();
        pstart = 1'b1;
        next_edge();
        pstart = 1'b0;
        @(negedge clk_audio);
        check("play_busy set", dut_busy, 1);
        check("melody first note", bus.note_sel, 0);
        seq.push_back(int'(bus.note_sel));
        prev = int'(bus.note_sel);
        steps_in = 0;
        busy_bad = 0;
        t1 = 0;
        while (bus.tone_en == 1'b1 && t1 < 800000) begin
            if (t1 == 5000) pstart = 1'b1;
            if (t1 == 5001) pstart = 1'b0;
            if (int'(bus.note_sel) != prev) begin
                check("steps per melody note", steps_in, 32);
                seq.push_back(int'(bus.note_sel));
                prev = int'(bus.note_sel);
                steps_in = 0;
            end
            if (bus.step == 1'b1) steps_in++;
            if (dut_busy != 1'b1) busy_bad++;
            @(negedge clk_audio);
            t1++;
        end
        check("steps in last note", steps_in, 32);
        check("busy low during melody", busy_bad, 0);
        check("busy cleared at idle", dut_busy, 0);
        check("melody length", seq.size(), 8);
        for (int i = 0; i < 8 && i < seq.size(); i++) check("melody note", seq[i], mel[i]);

        // abort by mi during the second note
        next_edge();
        pstart = 1'b1;
        next_edge();
        pstart = 1'b0;
        wait_for(3, 1, WAVE_MAX + 100, "melody reaches D");
        wait_for(0, 12, WAVE_MAX, "D addr 12");
        next_edge();
        drive_keys(4'b0100);
        wait_for(2, 1, WAVE_MAX, "abort at wrap");
        check("abort note_sel", bus.note_sel, 2);
        check("abort rom_addr", bus.rom_addr, 0);
        check("abort busy", dut_busy, 0);
        next_edge();
        drive_keys(4'b0);
        wait_for(1, 0, WAVE_MAX + 100, "idle after abort");
`endif

        cycles(5);
        finish_run();
    end
endmodule
